// File: rtl/scb_arbiter.sv
// Two-port arbiter sharing the single-ported SCB scratchpad between the CPU data
// port (m0) and the DMA/debug port (m1); one access per clock, completion one cycle later.
module scb_arbiter #(
  parameter int unsigned A    = 11,
  parameter int unsigned D    = 16,
  parameter int unsigned B    = 2,
  parameter int unsigned PRIO = 0
) (
  input  logic         clk_i,
  input  logic         rst_i,

  input  logic         m0_ce_i,
  input  logic         m0_wr_i,
  input  logic [A-1:0] m0_Addr_i,
  input  logic [D-1:0] m0_Data_i,
  input  logic [B-1:0] m0_stb_i,
  output logic [D-1:0] m0_Data_o,
  output logic         m0_rdy_o,

  input  logic         m1_ce_i,
  input  logic         m1_wr_i,
  input  logic [A-1:0] m1_Addr_i,
  input  logic [D-1:0] m1_Data_i,
  input  logic [B-1:0] m1_stb_i,
  output logic [D-1:0] m1_Data_o,
  output logic         m1_rdy_o,

  output logic         scb_ce_o,
  output logic         scb_rd_o,
  output logic         scb_wr_o,
  output logic [A-1:0] scb_Addr_o,
  output logic [D-1:0] scb_Data_o,
  output logic [B-1:0] scb_stb_o,
  input  logic [D-1:0] scb_Data_i
);

  logic [1:0]   inflight;
  logic [1:0]   wasread;
  logic         last_gnt;
  logic [D-1:0] hold0;
  logic [D-1:0] hold1;

  logic         elig0_c;
  logic         elig1_c;
  logic         gnt0_c;
  logic         gnt1_c;
  logic         rdvalid0_c;
  logic         rdvalid1_c;

  // A port is masked during its rdy cycle; reset also suppresses any grant immediately.
  always_comb begin
    elig0_c = m0_ce_i & ~inflight[0] & ~rst_i;
    elig1_c = m1_ce_i & ~inflight[1] & ~rst_i;
    gnt0_c  = 1'b0;
    gnt1_c  = 1'b0;
    if (elig0_c && elig1_c) begin
      if ((PRIO != 0) || last_gnt) begin
        gnt0_c = 1'b1;
      end else begin
        gnt1_c = 1'b1;
      end
    end else begin
      gnt0_c = elig0_c;
      gnt1_c = elig1_c;
    end
  end

  // Memory port follows the granted requester without any latching.
  always_comb begin
    scb_ce_o   = gnt0_c | gnt1_c;
    scb_rd_o   = 1'b0;
    scb_wr_o   = 1'b0;
    scb_Addr_o = '0;
    scb_Data_o = '0;
    scb_stb_o  = '0;
    if (gnt0_c) begin
      scb_rd_o   = ~m0_wr_i;
      scb_wr_o   = m0_wr_i;
      scb_Addr_o = m0_Addr_i;
      scb_Data_o = m0_Data_i;
      scb_stb_o  = m0_stb_i;
    end else if (gnt1_c) begin
      scb_rd_o   = ~m1_wr_i;
      scb_wr_o   = m1_wr_i;
      scb_Addr_o = m1_Addr_i;
      scb_Data_o = m1_Data_i;
      scb_stb_o  = m1_stb_i;
    end
  end

  assign rdvalid0_c = inflight[0] & wasread[0];
  assign rdvalid1_c = inflight[1] & wasread[1];

  // last_gnt: 1 means m1 was granted most recently, so m0 wins the first conflict after reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inflight <= 2'b00;
      wasread  <= 2'b00;
      last_gnt <= 1'b1;
      hold0    <= '0;
      hold1    <= '0;
    end else begin
      inflight <= {gnt1_c, gnt0_c};
      wasread  <= {gnt1_c & ~m1_wr_i, gnt0_c & ~m0_wr_i};
      if (gnt0_c) begin
        last_gnt <= 1'b0;
      end else if (gnt1_c) begin
        last_gnt <= 1'b1;
      end
      if (rdvalid0_c) begin
        hold0 <= scb_Data_i;
      end
      if (rdvalid1_c) begin
        hold1 <= scb_Data_i;
      end
    end
  end

  // Read data is passed straight through in the rdy cycle, then held.
  assign m0_rdy_o  = inflight[0];
  assign m1_rdy_o  = inflight[1];
  assign m0_Data_o = rdvalid0_c ? scb_Data_i : hold0;
  assign m1_Data_o = rdvalid1_c ? scb_Data_i : hold1;

endmodule

// File: tb/tb_scb_arbiter.sv
// Randomized and directed bench for scb_arbiter: two instances (round-robin and fixed
// priority) run against a cycle-level reference model with a byte-addressed golden memory.
module tb_scb_arbiter;

  localparam int unsigned A = 11;
  localparam int unsigned D = 16;
  localparam int unsigned B = 2;

  typedef struct packed {
    logic         wr;
    logic [A-1:0] a;
    logic [D-1:0] d;
    logic [B-1:0] s;
  } txn_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // [dut][port]; dut 0 is round-robin, dut 1 is m0-priority
  logic         ce    [2][2];
  logic         wr    [2][2];
  logic [A-1:0] addr  [2][2];
  logic [D-1:0] wdat  [2][2];
  logic [B-1:0] stb   [2][2];
  logic [D-1:0] rdat  [2][2];
  logic         rdy   [2][2];
  logic         s_ce  [2];
  logic         s_rd  [2];
  logic         s_wr  [2];
  logic [A-1:0] s_addr[2];
  logic [D-1:0] s_wdat[2];
  logic [B-1:0] s_stb [2];
  logic [D-1:0] s_rdat[2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    scb_arbiter #(.A(A), .D(D), .B(B), .PRIO(g)) u_dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .m0_ce_i    (ce[g][0]),
      .m0_wr_i    (wr[g][0]),
      .m0_Addr_i  (addr[g][0]),
      .m0_Data_i  (wdat[g][0]),
      .m0_stb_i   (stb[g][0]),
      .m0_Data_o  (rdat[g][0]),
      .m0_rdy_o   (rdy[g][0]),
      .m1_ce_i    (ce[g][1]),
      .m1_wr_i    (wr[g][1]),
      .m1_Addr_i  (addr[g][1]),
      .m1_Data_i  (wdat[g][1]),
      .m1_stb_i   (stb[g][1]),
      .m1_Data_o  (rdat[g][1]),
      .m1_rdy_o   (rdy[g][1]),
      .scb_ce_o   (s_ce[g]),
      .scb_rd_o   (s_rd[g]),
      .scb_wr_o   (s_wr[g]),
      .scb_Addr_o (s_addr[g]),
      .scb_Data_o (s_wdat[g]),
      .scb_stb_o  (s_stb[g]),
      .scb_Data_i (s_rdat[g])
    );
  end

  // Scratchpad behind each arbiter: word array, read data one cycle after the access
  logic [D-1:0] mem [2][1024];
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (s_ce[d]) begin
        if (s_wr[d]) begin
          if (s_stb[d][0]) mem[d][s_addr[d][A-1:1]][7:0]  <= s_wdat[d][7:0];
          if (s_stb[d][1]) mem[d][s_addr[d][A-1:1]][15:8] <= s_wdat[d][15:8];
        end else begin
          s_rdat[d] <= mem[d][s_addr[d][A-1:1]];
        end
      end
    end
  end

  // Reference model state
  logic [7:0]   bmem      [2][2048];
  int           last_gnt  [2][2];
  int           last_port [2];
  bit           was_rd    [2][2];
  logic [D-1:0] rd_val    [2][2];
  logic [D-1:0] hold      [2][2];
  bit           busy      [2][2];
  bit           pending   [2][2];
  txn_t         cur       [2][2];
  txn_t         script    [2][$];
  int           qi        [2][2];
  int           mode      [2];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit ce_on  = 0;
  bit rdy_on = 0;
  int n_ce   [2];
  int n_rdy  [2][2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic txn_t mk(input logic w, input logic [A-1:0] a, input logic [D-1:0] dd,
                              input logic [B-1:0] s);
    txn_t t;
    t.wr = w;
    t.a  = a;
    t.d  = dd;
    t.s  = s;
    return t;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      last_port[d] = 1;
      for (int p = 0; p < 2; p++) begin
        busy[d][p]     = 0;
        pending[d][p]  = 0;
        last_gnt[d][p] = -10;
        was_rd[d][p]   = 0;
        hold[d][p]     = '0;
        ce[d][p]       = 1'b0;
        wr[d][p]       = 1'b0;
        addr[d][p]     = '0;
        wdat[d][p]     = '0;
        stb[d][p]      = '0;
      end
    end
  endtask

  // Requesters: hold a request until its rdy cycle, present the next one the cycle after.
  task automatic drive(input int c);
    txn_t t;
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        if (busy[d][p] && !pending[d][p] && last_gnt[d][p] == c - 2) busy[d][p] = 0;
        if (!busy[d][p]) begin
          bit go;
          go = 0;
          case (mode[p])
            1:       go = ($urandom_range(0, 2) != 0);
            2:       go = 1;
            3:       go = (qi[d][p] < script[p].size());
            default: go = 0;
          endcase
          if (go) begin
            if (mode[p] == 3) begin
              t = script[p][qi[d][p]];
              qi[d][p]++;
            end else begin
              t = mk(1'($urandom_range(0, 1)), A'($urandom_range(0, 63)), D'($urandom),
                     B'($urandom_range(0, 3)));
            end
            cur[d][p]     = t;
            busy[d][p]    = 1;
            pending[d][p] = 1;
          end
        end
        ce[d][p]   = busy[d][p];
        wr[d][p]   = cur[d][p].wr;
        addr[d][p] = cur[d][p].a;
        wdat[d][p] = cur[d][p].d;
        stb[d][p]  = cur[d][p].s;
      end
    end
  endtask

  task automatic evaluate(input int c);
    for (int d = 0; d < 2; d++) begin
      int   g;
      int   a;
      bit   er;
      txn_t t;
      g = -1;
      if (pending[d][0] && pending[d][1]) g = (d == 1 || last_port[d] == 1) ? 0 : 1;
      else if (pending[d][0]) g = 0;
      else if (pending[d][1]) g = 1;
      check($sformatf("d%0d c%0d scb_ce", d, c), 32'(s_ce[d]), 32'(g >= 0));
      if (g >= 0) begin
        t = cur[d][g];
        check($sformatf("d%0d c%0d scb_wr", d, c), 32'(s_wr[d]), 32'(t.wr));
        check($sformatf("d%0d c%0d scb_rd", d, c), 32'(s_rd[d]), 32'(!t.wr));
        check($sformatf("d%0d c%0d scb_addr", d, c), 32'(s_addr[d]), 32'(t.a));
        check($sformatf("d%0d c%0d scb_wdata", d, c), 32'(s_wdat[d]), 32'(t.d));
        check($sformatf("d%0d c%0d scb_stb", d, c), 32'(s_stb[d]), 32'(t.s));
      end else begin
        check($sformatf("d%0d c%0d idle_rdwr", d, c), 32'({s_rd[d], s_wr[d]}), 32'd0);
        check($sformatf("d%0d c%0d idle_stb", d, c), 32'(s_stb[d]), 32'd0);
      end
      for (int p = 0; p < 2; p++) begin
        er = (last_gnt[d][p] == c - 1);
        check($sformatf("d%0d c%0d m%0d_rdy", d, c, p), 32'(rdy[d][p]), 32'(er));
        if (er && was_rd[d][p]) hold[d][p] = rd_val[d][p];
        check($sformatf("d%0d c%0d m%0d_data", d, c, p), 32'(rdat[d][p]), 32'(hold[d][p]));
      end
      if (g >= 0) begin
        a = int'(t.a);
        last_gnt[d][g] = c;
        last_port[d]   = g;
        pending[d][g]  = 0;
        was_rd[d][g]   = !t.wr;
        if (t.wr) begin
          if (t.s[0]) bmem[d][a & ~1] = t.d[7:0];
          if (t.s[1]) bmem[d][a | 1]  = t.d[15:8];
        end else begin
          rd_val[d][g] = {bmem[d][a | 1], bmem[d][a & ~1]};
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive(cyc);
    #3;
    evaluate(cyc);
    for (int d = 0; d < 2; d++) begin
      if (ce_on) n_ce[d] += int'(s_ce[d]);
      for (int p = 0; p < 2; p++) begin
        if (rdy_on) n_rdy[d][p] += int'(rdy[d][p]);
      end
    end
    cyc++;
  endtask

  task automatic clear_counts();
    for (int d = 0; d < 2; d++) begin
      n_ce[d] = 0;
      for (int p = 0; p < 2; p++) n_rdy[d][p] = 0;
    end
  endtask

  initial begin
    rst = 1'b1;
    model_reset();
    mode = '{0, 0};
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        qi[d][p]  = 0;
        cur[d][p] = '0;
      end
      for (int i = 0; i < 1024; i++) mem[d][i] = '0;
      for (int i = 0; i < 2048; i++) bmem[d][i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d reset_scb", d), 32'({s_ce[d], s_rd[d], s_wr[d], s_stb[d]}), 32'd0);
      check($sformatf("d%0d reset_rdy", d), 32'({rdy[d][1], rdy[d][0]}), 32'd0);
      check($sformatf("d%0d reset_data", d), 32'({rdat[d][1], rdat[d][0]}), 32'd0);
    end
    rst = 1'b0;

    // Random traffic: both ports, then each port alone
    mode = '{1, 1}; repeat (300) step();
    mode = '{1, 0}; repeat (40) step();
    mode = '{0, 1}; repeat (40) step();

    // Saturation from idle: full memory use, even split of completions
    mode = '{0, 0}; repeat (4) step();
    clear_counts();
    mode = '{2, 2};
    ce_on = 1; step();
    rdy_on = 1; repeat (19) step();
    mode = '{0, 0}; ce_on = 0; step();
    rdy_on = 0;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d sat_ce_count", d), 32'(n_ce[d]), 32'd20);
      check($sformatf("d%0d sat_m0_rdy", d), 32'(n_rdy[d][0]), 32'd10);
      check($sformatf("d%0d sat_m1_rdy", d), 32'(n_rdy[d][1]), 32'd10);
    end

    // One port alone gets at most one access every two cycles
    repeat (4) step();
    clear_counts();
    mode = '{2, 0};
    ce_on = 1; repeat (10) step();
    ce_on = 0; mode = '{0, 0};
    for (int d = 0; d < 2; d++) check($sformatf("d%0d solo_ce_count", d), 32'(n_ce[d]), 32'd5);

    // Reset during m0's rdy cycle
    repeat (4) step();
    mode = '{2, 0}; step();
    mode = '{0, 0};
    @(posedge clk);
    #1;
    drive(cyc);
    #1;
    for (int d = 0; d < 2; d++) check($sformatf("d%0d pre_rst_rdy", d), 32'(rdy[d][0]), 32'd1);
    rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d rst_rdy_drop", d), 32'(rdy[d][0]), 32'd0);
      check($sformatf("d%0d rst_data_zero", d), 32'(rdat[d][0]), 32'd0);
      check($sformatf("d%0d rst_scb_ce", d), 32'(s_ce[d]), 32'd0);
    end
    model_reset();
    #1;
    rst = 1'b0;
    cyc++;
    mode = '{2, 2}; step();
    mode = '{0, 0}; repeat (4) step();

    // Single write then read of 0x404
    script[0].push_back(mk(1'b1, 11'h404, 16'hBEEF, 2'b11));
    script[0].push_back(mk(1'b0, 11'h404, 16'h0000, 2'b11));
    mode = '{3, 3}; repeat (8) step();
    mode = '{0, 0}; repeat (2) step();
    for (int d = 0; d < 2; d++) check($sformatf("d%0d beef_hold", d), 32'(rdat[d][0]), 32'hBEEF);

    // Byte-lane merge at 0x002
    script[1].push_back(mk(1'b1, 11'h002, 16'h12AB, 2'b10));
    script[0].push_back(mk(1'b1, 11'h002, 16'hCD34, 2'b01));
    script[0].push_back(mk(1'b0, 11'h002, 16'h0000, 2'b11));
    mode = '{3, 3}; repeat (10) step();
    mode = '{0, 0}; repeat (2) step();
    for (int d = 0; d < 2; d++) check($sformatf("d%0d lane_merge", d), 32'(rdat[d][0]), 32'h1234);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
